// File: rtl/pace_pkg.sv
// Shared constants for the pace path: record layout,
// FSM encoding and the default rate limits.
package pace_pkg;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_FIFO_DEPTH   = 8;
  localparam int DEF_TICK_HZ      = 1000;
  localparam int DEF_MIN_INTERVAL = 500;
  localparam int DEF_MAX_INTERVAL = 1200;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_TIMING = 1'b1
  } state_e;

  function automatic int fast_bit(input int cnt_w);
    return cnt_w + 1;
  endfunction

  function automatic int slow_bit(input int cnt_w);
    return cnt_w;
  endfunction

endpackage

// File: rtl/pace_interval_monitor_if.sv
// Pace monitor bus: tick/pace inputs, FIFO readout
// and status outputs.
interface pace_interval_monitor_if #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic             tick_i;
  logic             pace_i;
  logic             rd_i;
  logic [CNT_W+1:0] data_o;
  logic             empty_o;
  logic [LW-1:0]    level_o;
  logic             overflow_o;
  logic             alarm_o;

  modport master (
    output tick_i, pace_i, rd_i,
    input  data_o, empty_o, level_o,
    input  overflow_o, alarm_o
  );

  modport slave (
    input  tick_i, pace_i, rd_i,
    output data_o, empty_o, level_o,
    output overflow_o, alarm_o
  );
endinterface

// File: rtl/pace_fifo.sv
// Show-ahead synchronous FIFO; head is visible on rdata
// whenever not empty, zero otherwise.
module pace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr;
  logic             rd;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign rd    = pop & ~empty;
  // a pop frees the slot this cycle, so push-while-full still lands
  assign wr    = push & (~full | rd);
  assign rdata = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      unique case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pace_interval_monitor.sv
// Times pace-to-pace intervals in ticks, flags rate
// violations, buffers records and raises a no-pace alarm.
module pace_interval_monitor
  import pace_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int MIN_INTERVAL = DEF_MIN_INTERVAL,
  parameter int MAX_INTERVAL = DEF_MAX_INTERVAL
) (
  input logic                     clk,
  input logic                     rst,
  pace_interval_monitor_if.slave  bus
);

  localparam int RW = CNT_W + 2;
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_INTERVAL);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INTERVAL);
  localparam logic [CNT_W-1:0] SAT_C = '1;

  logic             s1, s2, s3;
  logic [1:0]       warm;
  logic             pace_edge;
  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             alarm, ovf;
  logic             push, full;
  logic [RW-1:0]    rec;

  // s3 copies s1 until the chain is primed, so a level
  // already high at reset release is not taken as an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      warm <= '0;
    end else begin
      s1   <= bus.pace_i;
      s2   <= s1;
      s3   <= warm[1] ? s2 : s1;
      warm <= {warm[0], 1'b1};
    end
  end

  assign pace_edge = s2 & ~s3;
  assign push      = pace_edge & (state == S_TIMING);

  always_comb begin
    rec = '0;
    rec[fast_bit(CNT_W)] = (cnt < MIN_C);
    rec[slow_bit(CNT_W)] = (cnt > MAX_C);
    rec[CNT_W-1:0]       = cnt;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (pace_edge) begin
      state_nx = S_TIMING;
      cnt_nx   = '0;
    end else if (state == S_TIMING && bus.tick_i
                 && cnt != SAT_C) begin
      cnt_nx = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      alarm <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      alarm <= (state_nx == S_TIMING) && (cnt_nx > MAX_C);
      if (push && full && !bus.rd_i) ovf <= 1'b1;
    end
  end

  assign bus.alarm_o    = alarm;
  assign bus.overflow_o = ovf;

  pace_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (rec),
    .pop   (bus.rd_i),
    .rdata (bus.data_o),
    .empty (bus.empty_o),
    .full  (full),
    .level (bus.level_o)
  );

endmodule

// File: tb/tb_pace_interval_monitor.sv
// Scoreboard bench for pace_interval_monitor: expected
// records queued at each pulse, compared on readout.
module tb_pace_interval_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [17:0] q[$];
  logic exp_ovf = 1'b0;
  logic a_pre, a_post;

  always #5 clk = ~clk;

  pace_interval_monitor_if #(.CNT_W(16), .FIFO_DEPTH(8)) bus ();

  pace_interval_monitor #(
    .CNT_W        (16),
    .FIFO_DEPTH   (8),
    .MIN_INTERVAL (500),
    .MAX_INTERVAL (1200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [17:0] mk_rec(input int n);
    logic [15:0] v;
    v = n[15:0];
    return {n < 500, n > 1200, v};
  endfunction

  task automatic push_exp(input int n);
    if (q.size() < 8) q.push_back(mk_rec(n));
    else exp_ovf = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_i = 1'b1;
      @(negedge clk);
      bus.tick_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse(input bit with_tick, input bit with_rd);
    bus.pace_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_pre = bus.alarm_o;
    bus.tick_i = with_tick;
    if (with_rd) begin
      chk("coinc_head", 32'(bus.data_o), 32'(q.pop_front()));
      bus.rd_i = 1'b1;
    end
    @(negedge clk);
    bus.tick_i = 1'b0;
    bus.rd_i   = 1'b0;
    a_post = bus.alarm_o;
    repeat (2) @(negedge clk);
    bus.pace_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) begin
      chk({tag, "_nonempty"}, 32'(bus.empty_o), 0);
      chk({tag, "_data"}, 32'(bus.data_o), 32'(q.pop_front()));
      bus.rd_i = 1'b1;
      @(negedge clk);
      bus.rd_i = 1'b0;
    end
    chk({tag, "_empty"}, 32'(bus.empty_o), 1);
    chk({tag, "_level"}, 32'(bus.level_o), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(bus.empty_o), 1);
    chk({tag, "_level"}, 32'(bus.level_o), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow_o), 0);
    chk({tag, "_alarm"}, 32'(bus.alarm_o), 0);
    chk({tag, "_data"}, 32'(bus.data_o), 0);
  endtask

  initial begin
    bus.tick_i = 1'b0;
    bus.pace_i = 1'b0;
    bus.rd_i   = 1'b0;
    @(negedge clk);
    do_reset();
    chk_reset_vals("rst");

    // basic 800-tick pacing; first pulse only arms
    pulse(0, 0);
    chk("arm_level", 32'(bus.level_o), 0);
    chk("arm_empty", 32'(bus.empty_o), 1);
    for (int i = 0; i < 2; i++) begin
      ticks(800);
      pulse(0, 0);
      push_exp(800);
    end
    chk("basic_alarm", 32'(bus.alarm_o), 0);
    chk("basic_level", 32'(bus.level_o), 2);
    drain("basic");

    // rate-limit boundaries
    begin
      int iv [4] = '{300, 500, 1200, 1201};
      foreach (iv[i]) begin
        ticks(iv[i]);
        pulse(0, 0);
        push_exp(iv[i]);
      end
    end
    chk("bnd_level", 32'(bus.level_o), 4);
    drain("bnd");
    chk("bnd_alarm", 32'(bus.alarm_o), 0);

    // alarm on silence
    ticks(1200);
    chk("alarm_at_1200", 32'(bus.alarm_o), 0);
    bus.tick_i = 1'b1;
    @(negedge clk);
    bus.tick_i = 1'b0;
    chk("alarm_at_1201", 32'(bus.alarm_o), 1);
    @(negedge clk);
    ticks(299);
    chk("alarm_held", 32'(bus.alarm_o), 1);
    pulse(0, 0);
    push_exp(1500);
    chk("alarm_pre_clear", 32'(a_pre), 1);
    chk("alarm_cleared", 32'(a_post), 0);
    drain("alarm");

    // edge coincident with tick: pre-increment value kept
    ticks(799);
    pulse(1, 0);
    push_exp(799);
    ticks(800);
    pulse(0, 0);
    push_exp(800);
    drain("coinc");

    // fill, push+pop at full, then overflow
    do_reset();
    pulse(0, 0);
    for (int i = 0; i < 8; i++) begin
      ticks(800);
      pulse(0, 0);
      push_exp(800);
    end
    chk("full_level", 32'(bus.level_o), 8);
    chk("full_ovf", 32'(bus.overflow_o), 0);
    ticks(700);
    pulse(0, 1);
    push_exp(700);
    chk("pp_level", 32'(bus.level_o), 8);
    chk("pp_ovf", 32'(bus.overflow_o), 0);
    ticks(600);
    pulse(0, 0);
    push_exp(600);
    chk("ovf_level", 32'(bus.level_o), 8);
    chk("ovf_flag", 32'(bus.overflow_o), 32'(exp_ovf));
    drain("ovf");
    bus.rd_i = 1'b1;
    @(negedge clk);
    bus.rd_i = 1'b0;
    chk("rd_empty_level", 32'(bus.level_o), 0);
    chk("rd_empty_flag", 32'(bus.empty_o), 1);
    chk("ovf_sticky", 32'(bus.overflow_o), 1);

    // async reset mid-interval with pace held high
    ticks(400);
    pulse(0, 0);
    push_exp(400);
    ticks(1300);
    chk("pre_rst_alarm", 32'(bus.alarm_o), 1);
    chk("pre_rst_level", 32'(bus.level_o), 1);
    bus.pace_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    q.delete();
    exp_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_no_rec", 32'(bus.level_o), 0);
    ticks(10);
    chk("held_no_alarm", 32'(bus.alarm_o), 0);
    bus.pace_i = 1'b0;
    repeat (4) @(negedge clk);
    pulse(0, 0);
    chk("rearm_level", 32'(bus.level_o), 0);
    ticks(250);
    pulse(0, 0);
    push_exp(250);
    chk("post_rst_level", 32'(bus.level_o), 1);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pace_interval_monitor.md
Name: pace_interval_monitor

Overview:
- Sits directly downstream of the pace-widening stage and consumes its widened pace output.
- Measures the interval between successive pace events in ticks of a 1 kHz strobe.
- Classifies each interval against rate limits and buffers {flags, interval} records in a small FIFO for host/UART readout.
- Drives a live alarm when pacing stops for longer than the lower-rate limit.

Parameters:
- CNT_W, 16: interval counter width in ticks.
- FIFO_DEPTH, 8: number of FIFO entries; must be a power of 2, at least 2.
- MIN_INTERVAL, 500: intervals strictly below this are flagged fast (upper-rate violation, 120 bpm at a 1 ms tick).
- MAX_INTERVAL, 1200: intervals strictly above this are flagged slow; also the alarm threshold (50 bpm).

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- tick_i  in  1  one-clk-wide interval tick strobe (1 kHz), synchronous to clk.
- pace_i  in  1  widened pace level from the upstream stage; asynchronous to clk.
- rd_i  in  1  pop the head FIFO entry.
- data_o  out  CNT_W+2  head entry {fast, slow, interval[CNT_W-1:0]}; valid while empty_o=0.
- empty_o  out  1  FIFO empty.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_o  out  1  sticky: a record was dropped because the FIFO was full.
- alarm_o  out  1  no pace seen for more than MAX_INTERVAL ticks.

Behaviour:
- Reset values, applied asynchronously on rst=1: sync flops 0, counter 0, state IDLE, FIFO empty, empty_o=1, level_o=0, overflow_o=0, alarm_o=0, data_o=0.
- Input capture: pace_i goes through a 2-flop synchroniser (s1, s2) and a delay flop s3. edge = s2 & ~s3.
- Latency: if pace_i is first sampled high at clock k, edge is high in the cycle after clock k+1, the push is registered at clock k+2, and empty_o falls after clock k+2.
- States:
  - IDLE: no pace seen since reset. On edge: counter cleared to 0, go to TIMING, no push.
  - TIMING: counter increments on tick_i and saturates at 2^CNT_W-1 (no wrap). On edge: push {cnt<MIN_INTERVAL, cnt>MAX_INTERVAL, cnt}, then counter cleared to 0 and state stays TIMING.
- Edge and tick_i in the same cycle: the recorded interval is the pre-increment cnt, and the counter loads 0. The tick is discarded.
- Saturated interval: record interval = all ones and slow=1.
- alarm_o: registered, equal to (state==TIMING && cnt>MAX_INTERVAL). It rises the cycle after the tick that takes cnt to MAX_INTERVAL+1 and falls the cycle after the edge that clears the counter. It is never asserted in IDLE.
- FIFO: show-ahead. data_o presents the head combinationally from storage whenever empty_o=0.
  - rd_i while empty: ignored.
  - Push while full without a simultaneous pop: record dropped, overflow_o set. overflow_o clears only on rst.
  - Push and pop in the same cycle, any level including full: both succeed and level is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full = level_o==FIFO_DEPTH.
- Reset mid-interval or while pace_i is high: everything returns to reset values immediately. If pace_i is still high after reset release, s3 reaches 1 together with s2, so no edge is detected until pace_i falls and rises again.
- Upstream guarantee: widened pulses are at least several clk wide, so no pulse can be missed by the synchroniser.

Decomposition:
- Shared package pace_pkg holds:
  - the record field offsets (FAST_BIT=CNT_W+1, SLOW_BIT=CNT_W);
  - the state encoding constants (S_IDLE=0, S_TIMING=1);
  - the default rate-limit constants, shared with the pace-widening stage's tick rate.
- One sub-module, pace_fifo: a parameterised show-ahead synchronous FIFO (width, depth) providing empty/level/full, with async active-high reset. It is reusable by the sense-event logger.

Test Plan:
- Reset, then 3 pace pulses 800 ticks apart -> the first pulse gives no record; 2 records {0,0,800}; alarm_o stays 0; level_o=2.
- Pulses 300 ticks apart -> record {1,0,300}. Pulses 500 apart -> {0,0,500}; 1200 -> {0,0,1200}; 1201 -> {0,1,1201}. This checks the strict boundaries.
- A single pulse, then silence -> alarm_o rises the cycle after the 1201st tick. The next pulse yields {0,1,N} with N equal to the ticks elapsed, and alarm_o falls one cycle later.
- 10 pulses at 800 ticks with no reads -> 9 intervals produced, 8 stored, level_o=8, overflow_o=1. Reading out returns 8 entries of 800, then empty_o=1. A further rd_i leaves level_o=0.
- FIFO full, then edge and rd_i in the same cycle -> level_o stays 8, the new record is stored, and overflow_o is not newly set. Separately, an edge coincident with tick_i at cnt=799 records 799.
- Assert rst mid-interval with pace_i held high -> all outputs return to reset values asynchronously. No record after release until pace_i falls and rises; that first edge only arms TIMING.
